// File: rtl/tapped_shreg.sv
// Parametrised tapped shift register: configurable depth, two inverting taps,
// shift enable, synchronous parallel load, run-time direction and fill flag.
module tapped_shreg #(
   parameter int               DEPTH = 16,
   parameter int               TAPA  = 1,
   parameter int               TAPB  = 2,
   parameter int               INVA  = 0,
   parameter int               INVB  = 0,
   parameter logic [DEPTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             en,
   input  logic             dir,
   input  logic             sin,
   input  logic             load,
   input  logic [DEPTH-1:0] pdata,
   output logic [DEPTH-1:0] q,
   output logic             outa,
   output logic             outb,
   output logic             sout,
   output logic             full
);

   localparam int                CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   // Reject illegal configurations at elaboration instead of clamping them.
   if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("tapped_shreg: DEPTH=%0d outside 2..64", DEPTH);
   end
   if (TAPA < 0 || TAPA >= DEPTH) begin : g_bad_tapa
      $error("tapped_shreg: TAPA=%0d must be in 0..DEPTH-1", TAPA);
   end
   if (TAPB < 0 || TAPB >= DEPTH) begin : g_bad_tapb
      $error("tapped_shreg: TAPB=%0d must be in 0..DEPTH-1", TAPB);
   end
   if (INVA != 0 && INVA != 1) begin : g_bad_inva
      $error("tapped_shreg: INVA=%0d must be 0 or 1", INVA);
   end
   if (INVB != 0 && INVB != 1) begin : g_bad_invb
      $error("tapped_shreg: INVB=%0d must be 0 or 1", INVB);
   end

   logic [DEPTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;

   // Load beats shift; the fill count only advances on shifts and stops at DEPTH.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_q   <= INIT;
         r_cnt <= '0;
      end else if (load) begin
         r_q   <= pdata;
         r_cnt <= CNT_MAX;
      end else if (en) begin
         if (dir) begin
            r_q <= {sin, r_q[DEPTH-1:1]};
         end else begin
            r_q <= {r_q[DEPTH-2:0], sin};
         end
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   logic w_inva;
   logic w_invb;

   assign w_inva = (INVA != 0);
   assign w_invb = (INVB != 0);

   assign q    = r_q;
   assign outa = r_q[TAPA] ^ w_inva;
   assign outb = r_q[TAPB] ^ w_invb;
   assign sout = dir ? r_q[0] : r_q[DEPTH-1];
   assign full = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_tapped_shreg.sv
// Directed bench for tapped_shreg: two instances share stimulus, one with
// INIT=16'hA5C3 and an inverted tap A, one with INIT=0 for latency checks.
module tb_tapped_shreg;

   logic        clk;
   logic        nRST;
   logic        en;
   logic        dir;
   logic        sin;
   logic        load;
   logic [15:0] pdata;

   logic [15:0] q0, q1;
   logic        outa0, outb0, sout0, full0;
   logic        outa1, outb1, sout1, full1;

   int n_checks = 0;
   int n_err    = 0;

   tapped_shreg #(
      .DEPTH(16), .TAPA(1), .TAPB(2), .INVA(1), .INVB(0), .INIT(16'hA5C3)
   ) dut0 (
      .clk(clk), .nRST(nRST), .en(en), .dir(dir), .sin(sin), .load(load),
      .pdata(pdata), .q(q0), .outa(outa0), .outb(outb0), .sout(sout0),
      .full(full0)
   );

   tapped_shreg #(
      .DEPTH(16), .TAPA(1), .TAPB(2), .INVA(0), .INVB(0), .INIT(16'h0000)
   ) dut1 (
      .clk(clk), .nRST(nRST), .en(en), .dir(dir), .sin(sin), .load(load),
      .pdata(pdata), .q(q1), .outa(outa1), .outb(outb1), .sout(sout1),
      .full(full1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed between edges; checks the immediate effect.
   task automatic rst_pulse(input string tag);
      #2 nRST = 1'b0;
      #1;
      check({tag, "_q0"},    32'(q0),    32'h0000A5C3);
      check({tag, "_full0"}, 32'(full0), 32'd0);
      check({tag, "_q1"},    32'(q1),    32'd0);
      check({tag, "_full1"}, 32'(full1), 32'd0);
      #2 nRST = 1'b1;
   endtask

   initial begin
      nRST  = 1'b1;
      en    = 1'b0;
      dir   = 1'b0;
      sin   = 1'b0;
      load  = 1'b0;
      pdata = 16'h0000;

      // Reset asserted between edges takes effect immediately
      #2 nRST = 1'b0;
      #1;
      check("rst_q0",    32'(q0),    32'h0000A5C3);
      check("rst_outa0", 32'(outa0), 32'd0);
      check("rst_outb0", 32'(outb0), 32'd0);
      check("rst_sout0", 32'(sout0), 32'd1);
      check("rst_full0", 32'(full0), 32'd0);
      check("rst_q1",    32'(q1),    32'd0);
      check("rst_full1", 32'(full1), 32'd0);

      // Reset held low overrides load and en across an edge
      load  = 1'b1;
      en    = 1'b1;
      pdata = 16'hFFFF;
      tick();
      check("rst_hold_q0",    32'(q0),    32'h0000A5C3);
      check("rst_hold_full0", 32'(full0), 32'd0);
      load = 1'b0;
      en   = 1'b0;
      #2 nRST = 1'b1;

      // Impulse latency, continuous enable, dir=0
      en  = 1'b1;
      sin = 1'b1;
      tick();
      sin = 1'b0;
      check("imp_q1_e1",   32'(q1),    32'h0001);
      check("imp_outa_e1", 32'(outa1), 32'd0);
      tick();
      check("imp_outa_e2", 32'(outa1), 32'd1);
      check("imp_outb_e2", 32'(outb1), 32'd0);
      tick();
      check("imp_outa_e3", 32'(outa1), 32'd0);
      check("imp_outb_e3", 32'(outb1), 32'd1);
      for (int e = 4; e <= 15; e++) begin
         tick();
         check("imp_sout_early", 32'(sout1), 32'd0);
         if (e == 15) check("imp_full_e15", 32'(full1), 32'd0);
      end
      tick();
      check("imp_sout_e16", 32'(sout1), 32'd1);
      check("imp_full_e16", 32'(full1), 32'd1);
      tick();
      check("imp_sout_e17", 32'(sout1), 32'd0);
      check("imp_full_e17", 32'(full1), 32'd1);

      en = 1'b0;
      rst_pulse("rstA");

      // Enable gating: shifts accepted only on even edges
      sin = 1'b1;
      en  = 1'b0;
      tick();
      check("gate_hold_q1", 32'(q1), 32'd0);
      en = 1'b1;
      tick();
      check("gate_q1_e2", 32'(q1), 32'h0001);
      sin = 1'b0;
      for (int e = 3; e <= 32; e++) begin
         en = (e % 2 == 0);
         tick();
         if (e == 3) check("gate_outa_e3", 32'(outa1), 32'd0);
         if (e == 4) check("gate_outa_e4", 32'(outa1), 32'd1);
         if (e == 5) check("gate_outa_e5", 32'(outa1), 32'd1);
         if (e == 6) begin
            check("gate_outa_e6", 32'(outa1), 32'd0);
            check("gate_outb_e6", 32'(outb1), 32'd1);
         end
         if (e == 31) begin
            check("gate_full_e31", 32'(full1), 32'd0);
            check("gate_sout_e31", 32'(sout1), 32'd0);
         end
      end
      check("gate_full_e32", 32'(full1), 32'd1);
      check("gate_sout_e32", 32'(sout1), 32'd1);

      en = 1'b0;
      rst_pulse("rstB");

      // Load wins over shift
      load  = 1'b1;
      en    = 1'b1;
      sin   = 1'b0;
      dir   = 1'b0;
      pdata = 16'h8001;
      tick();
      load = 1'b0;
      check("load_q0",    32'(q0),    32'h8001);
      check("load_full0", 32'(full0), 32'd1);
      check("load_outa0", 32'(outa0), 32'd1);
      check("load_outb0", 32'(outb0), 32'd0);
      check("load_sout0", 32'(sout0), 32'd1);
      check("load_q1",    32'(q1),    32'h8001);
      check("load_full1", 32'(full1), 32'd1);
      dir = 1'b1;
      repeat (3) tick();
      check("load_shr_q0",   32'(q0),    32'h1000);
      check("load_shr_sout", 32'(sout0), 32'd0);

      // Hold with en=0
      en = 1'b0;
      tick();
      check("hold_q0", 32'(q0), 32'h1000);

      // Direction change
      load  = 1'b1;
      pdata = 16'h0001;
      tick();
      load = 1'b0;
      en   = 1'b1;
      dir  = 1'b0;
      sin  = 1'b0;
      tick();
      check("dir_q0_left", 32'(q0), 32'h0002);
      dir = 1'b1;
      sin = 1'b1;
      tick();
      check("dir_q0_right", 32'(q0),    32'h8001);
      check("dir_full0",    32'(full0), 32'd1);
      en = 1'b0;
      pdata = 16'h4002;
      load  = 1'b1;
      tick();
      load = 1'b0;
      dir  = 1'b0;
      #1;
      check("dir_sout_d0", 32'(sout0), 32'd0);
      dir = 1'b1;
      #1;
      check("dir_sout_d1", 32'(sout0), 32'd0);
      pdata = 16'h8000;
      load  = 1'b1;
      tick();
      load = 1'b0;
      check("dir_sout_d1b", 32'(sout0), 32'd0);
      dir = 1'b0;
      #1;
      check("dir_sout_d0b", 32'(sout0), 32'd1);

      rst_pulse("rstC");

      // Reset during a run of shifts at cnt=9
      en  = 1'b1;
      dir = 1'b0;
      sin = 1'b1;
      tick();
      check("run_first_q0", 32'(q0), 32'h4B87);
      repeat (8) tick();
      check("run_q0_9",    32'(q0),    32'h87FF);
      check("run_full0_9", 32'(full0), 32'd0);
      #2 nRST = 1'b0;
      #1;
      check("mid_rst_q0",    32'(q0),    32'h0000A5C3);
      check("mid_rst_full0", 32'(full0), 32'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      check("mid_rst_hold_q0", 32'(q0), 32'h0000A5C3);
      #4 nRST = 1'b1;

      // Fresh 16 accepted shifts, direction alternating, are needed for full
      for (int i = 0; i < 16; i++) begin
         dir = i[0];
         sin = 1'($urandom);
         tick();
         if (i == 14) begin
            check("refill_full0_15", 32'(full0), 32'd0);
            check("refill_full1_15", 32'(full1), 32'd0);
         end
      end
      check("refill_full0_16", 32'(full0), 32'd1);
      check("refill_full1_16", 32'(full1), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
